clic_irq_scan_arbiter: RTL and testbench
========================================

// Module: clic_irq_scan_arbiter
// PURPOSE
//  Sequential CLIC interrupt arbiter, placed between the CLIC pending/enable/ctl register file and the hart.
//  Scans all sources in fixed-size chunks, one chunk per cycle, and keeps a running best.
//  At the end of each sweep it offers the highest-ranked eligible interrupt on a valid/ready port.
//  Trades arbitration latency for area compared with a flat 256-input comparator tree.
// PARAMETERS
//  NumSrc      256               number of interrupt sources (matches CLICNumInterruptSrc)
//  IntCtlBits  8                 width of per-source clicintctl (level/priority)
//  SrcPerCycle 16                sources evaluated per cycle; NumSrc % SrcPerCycle == 0 is required
//  IdWidth     $clog2(NumSrc)    width of interrupt ID
// PORTS
//  clk_i        in   1                    clock
//  rst_ni       in   1                    asynchronous active-low reset
//  ip_i         in   NumSrc               per-source pending bit
//  ie_i         in   NumSrc               per-source enable bit
//  ctl_i        in   NumSrc*IntCtlBits    per-source clicintctl, packed [NumSrc-1:0][IntCtlBits-1:0]
//  thresh_i     in   IntCtlBits           mintthresh; only ctl > thresh_i is eligible
//  irq_valid_o  out  1                    winning interrupt offered
//  irq_id_o     out  IdWidth              winning source ID
//  irq_ctl_o    out  IntCtlBits           winning source ctl
//  irq_ready_i  in   1                    hart accepts the offer
// BEHAVIOUR
//  Reset values: state=SCAN, chunk cnt=0, best_vld=0, best_id=0, best_ctl=0,
//    irq_valid_o=0, irq_id_o=0, irq_ctl_o=0.
//  Eligibility of source i: ip_i[i] & ie_i[i] & (ctl_i[i] > thresh_i), unsigned compare.
//    All inputs are sampled live every cycle.
//  Ranking: higher ctl wins; on equal ctl, the higher ID wins.
//  SCAN, cnt=c:
//    - Evaluate sources c*SrcPerCycle .. c*SrcPerCycle+SrcPerCycle-1 with a combinational max tree.
//    - The chunk winner replaces best if !best_vld, or if chunk_ctl >= best_ctl.
//      Chunk IDs are always above earlier IDs, so >= implements the ID tie-break.
//  Last chunk (cnt = NumSrc/SrcPerCycle-1):
//    - If the final best (this chunk included) is valid:
//      irq_valid_o<=1, irq_id_o/irq_ctl_o<=final best, state<=OFFER.
//    - Otherwise stay in SCAN.
//    - In both cases: cnt<=0, best_vld<=0 (wrap-around, next sweep starts clean).
//  Latency: offer appears NumSrc/SrcPerCycle cycles after the cnt=0 cycle (16 at defaults).
//    Worst case from a pend event to valid is 2 sweeps.
//  OFFER:
//    - irq_valid_o, irq_id_o and irq_ctl_o are held stable. No scanning occurs.
//    - A newly pending, higher-ranked source does not preempt the offer; it is picked up on the next sweep.
//    - irq_valid_o & irq_ready_i is a handshake: irq_valid_o<=0, state<=SCAN, cnt<=0. IDs/ctl keep last value.
//    - Retraction: if source irq_id_o is no longer eligible (ip/ie dropped, or thresh_i raised) and irq_ready_i=0:
//      irq_valid_o<=0, state<=SCAN, cnt<=0.
//    - Retraction takes effect one cycle later. A handshake in the cycle before the drop still counts.
//    - Retraction and handshake in the same cycle: the handshake takes precedence (single accept, same next state).
//  Retraction deliberately deviates from strict valid/ready stability; the hart must tolerate a dropped valid.
//  thresh_i change mid-sweep: chunks already folded into best are not re-evaluated.
//    The OFFER-state eligibility check catches a stale winner.
//  Asynchronous reset mid-sweep or mid-offer returns to the reset values immediately;
//    no partial handshake is reported.
//  Elaboration assertion: NumSrc % SrcPerCycle == 0, SrcPerCycle >= 1.
// TESTING (defaults: 256 sources, 16 per cycle)
//  1. Reset, thresh=0, only src 37 pending+enabled with ctl=0x40, ready=0
//     -> irq_valid_o=1 within 32 cycles; id=37, ctl=0x40; outputs stable for 20 cycles.
//  2. Src 5 and 200 both ctl=0x80 -> id=200. Then src 5 ctl=0x90, src 200 ctl=0x80 -> id=5.
//  3. Src 37 ctl=0x40, thresh=0x40 -> irq_valid_o stays 0 for 100 cycles.
//     Set thresh=0x3F -> valid, id=37.
//  4. Offer id=37 with ready=0; clear ip[37] -> irq_valid_o falls the next cycle, no handshake.
//     New valid only if another source is eligible.
//  5. Ready held low 10 cycles, then a 1-cycle ready pulse -> exactly one handshake.
//     Valid drops; with src 37 still pending, id=37 is re-offered exactly 16 cycles later.
//  6. Assert rst_ni low during cnt=7 of a sweep and during OFFER
//     -> all outputs 0 immediately; after release, the first offer comes from a full fresh sweep.

Source files
------------

// File: rtl/clic_irq_scan_arbiter.sv
// Sequential CLIC interrupt arbiter.
// Each cycle it looks at one chunk of SrcPerCycle sources and folds the best
// eligible source of that chunk into a running best. After the last chunk, a
// valid best is offered to the hart on a valid/ready port. The offer is held
// until it is accepted or until the offered source stops being eligible.
module clic_irq_scan_arbiter #(
  parameter int NumSrc      = 256,
  parameter int IntCtlBits  = 8,
  parameter int SrcPerCycle = 16,
  parameter int IdWidth     = $clog2(NumSrc)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumSrc-1:0]                    ip_i,
  input  logic [NumSrc-1:0]                    ie_i,
  input  logic [NumSrc-1:0][IntCtlBits-1:0]    ctl_i,
  input  logic [IntCtlBits-1:0]                thresh_i,
  output logic                                 irq_valid_o,
  output logic [IdWidth-1:0]                   irq_id_o,
  output logic [IntCtlBits-1:0]                irq_ctl_o,
  input  logic                                 irq_ready_i
);

  localparam int NumChunks = NumSrc / SrcPerCycle;
  localparam int CntWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumChunks - 1);

  // Reject configurations where the chunks do not tile the sources exactly
  if ((SrcPerCycle < 1) || ((NumSrc % SrcPerCycle) != 0)) begin : g_bad_cfg
    $error("clic_irq_scan_arbiter: NumSrc must be a multiple of SrcPerCycle (>= 1)");
  end

  typedef enum logic {SCAN, OFFER} state_e;

  state_e                  state_reg, state_next;
  logic [CntWidth-1:0]     cnt_reg, cnt_next;
  logic                    best_vld_reg, best_vld_next;
  logic [IdWidth-1:0]      best_id_reg, best_id_next;
  logic [IntCtlBits-1:0]   best_ctl_reg, best_ctl_next;
  logic                    valid_reg, valid_next;
  logic [IdWidth-1:0]      id_reg, id_next;
  logic [IntCtlBits-1:0]   ctl_reg, ctl_next;

  logic [SrcPerCycle-1:0]  lane_elig;
  logic [IdWidth-1:0]      lane_id  [SrcPerCycle];
  logic [IntCtlBits-1:0]   lane_ctl [SrcPerCycle];

  logic                    chunk_vld;
  logic [IdWidth-1:0]      chunk_id;
  logic [IntCtlBits-1:0]   chunk_ctl;

  logic                    fold;
  logic                    final_vld;
  logic [IdWidth-1:0]      final_id;
  logic [IntCtlBits-1:0]   final_ctl;
  logic                    last_chunk;
  logic                    offer_elig;
  logic                    offer_end;

  // Per-lane source selection and eligibility for the chunk addressed by cnt
  for (genvar gi = 0; gi < SrcPerCycle; gi++) begin : g_lane
    assign lane_id[gi]   = IdWidth'(int'(cnt_reg) * SrcPerCycle + gi);
    assign lane_ctl[gi]  = ctl_i[lane_id[gi]];
    assign lane_elig[gi] = ip_i[lane_id[gi]] & ie_i[lane_id[gi]] &
                           (ctl_i[lane_id[gi]] > thresh_i);
  end

  // Chunk winner: later lanes carry higher IDs, so >= gives ties to the higher ID
  always_comb begin
    chunk_vld = 1'b0;
    chunk_id  = '0;
    chunk_ctl = '0;
    for (int j = 0; j < SrcPerCycle; j++) begin
      if (lane_elig[j] && (!chunk_vld || (lane_ctl[j] >= chunk_ctl))) begin
        chunk_vld = 1'b1;
        chunk_id  = lane_id[j];
        chunk_ctl = lane_ctl[j];
      end
    end
  end

  // Merge chunk winner into the running best and check the live offer
  always_comb begin
    fold       = chunk_vld && (!best_vld_reg || (chunk_ctl >= best_ctl_reg));
    final_vld  = best_vld_reg | chunk_vld;
    final_id   = fold ? chunk_id  : best_id_reg;
    final_ctl  = fold ? chunk_ctl : best_ctl_reg;
    last_chunk = (cnt_reg == LastCnt);
    offer_elig = ip_i[id_reg] & ie_i[id_reg] & (ctl_i[id_reg] > thresh_i);
    // Handshake wins over retraction; both lead back to a fresh sweep
    offer_end  = irq_ready_i | ~offer_elig;
  end

  // State register plus datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= SCAN;
      cnt_reg      <= '0;
      best_vld_reg <= 1'b0;
      best_id_reg  <= '0;
      best_ctl_reg <= '0;
      valid_reg    <= 1'b0;
      id_reg       <= '0;
      ctl_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      best_vld_reg <= best_vld_next;
      best_id_reg  <= best_id_next;
      best_ctl_reg <= best_ctl_next;
      valid_reg    <= valid_next;
      id_reg       <= id_next;
      ctl_reg      <= ctl_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SCAN:    if (last_chunk && final_vld) state_next = OFFER;
      OFFER:   if (offer_end)               state_next = SCAN;
      default: state_next = SCAN;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_next      = cnt_reg;
    best_vld_next = best_vld_reg;
    best_id_next  = best_id_reg;
    best_ctl_next = best_ctl_reg;
    valid_next    = valid_reg;
    id_next       = id_reg;
    ctl_next      = ctl_reg;
    case (state_reg)
      SCAN: begin
        best_id_next  = final_id;
        best_ctl_next = final_ctl;
        if (last_chunk) begin
          cnt_next      = '0;
          best_vld_next = 1'b0;
          if (final_vld) begin
            valid_next = 1'b1;
            id_next    = final_id;
            ctl_next   = final_ctl;
          end
        end else begin
          cnt_next      = cnt_reg + 1'b1;
          best_vld_next = final_vld;
        end
      end
      OFFER: begin
        if (offer_end) begin
          valid_next = 1'b0;
          cnt_next   = '0;
        end
      end
      default: begin
        valid_next = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  assign irq_valid_o = valid_reg;
  assign irq_id_o    = id_reg;
  assign irq_ctl_o   = ctl_reg;

endmodule

// File: tb/tb_clic_irq_scan_arbiter.sv
// Directed bench for clic_irq_scan_arbiter at default parameters.
module tb_clic_irq_scan_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [255:0]      ip;
  logic [255:0]      ie;
  logic [255:0][7:0] ctl;
  logic [7:0]        thresh;
  logic              valid;
  logic [7:0]        id;
  logic [7:0]        ctlo;
  logic              ready;

  int errors = 0;
  int checks = 0;

  clic_irq_scan_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ip_i        (ip),
    .ie_i        (ie),
    .ctl_i       (ctl),
    .thresh_i    (thresh),
    .irq_valid_o (valid),
    .irq_id_o    (id),
    .irq_ctl_o   (ctlo),
    .irq_ready_i (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ip     = '0;
    ie     = '0;
    ctl    = '0;
    thresh = '0;
    ready  = 1'b0;
  endtask

  // Reset released just after an edge, so the next edge evaluates chunk 0
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!valid && n < budget) begin
      tick();
      n++;
    end
    if (valid) $display("[%0t] offer id=%0d ctl=0x%0h after %0d cycles", $time, id, ctlo, n);
  endtask

  task automatic test_reset();
    clear_inputs();
    ip[3] = 1'b1; ie[3] = 1'b1; ctl[3] = 8'h10;
    rst_n = 1'b0;
    #2;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (id !== 8'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", id); end
    checks++; if (ctlo !== 8'h00) begin errors++; $display("FAIL reset_ctl: got 0x%0h expected 0x00", ctlo); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b expected 0", valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n;
    bit stable;
    clear_inputs();
    ip[37] = 1'b1; ie[37] = 1'b1; ctl[37] = 8'h40;
    do_reset();
    wait_valid(32, n);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", valid); end
    checks++; if (n !== 16) begin errors++; $display("FAIL single_latency: got %0d expected 16", n); end
    checks++; if (id !== 8'd37) begin errors++; $display("FAIL single_id: got %0d expected 37", id); end
    checks++; if (ctlo !== 8'h40) begin errors++; $display("FAIL single_ctl: got 0x%0h expected 0x40", ctlo); end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid !== 1'b1 || id !== 8'd37 || ctlo !== 8'h40) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL single_stable: got valid=%b id=%0d ctl=0x%0h expected 1/37/0x40", valid, id, ctlo); end
  endtask

  task automatic test_tie_break();
    int n;
    clear_inputs();
    ip[5] = 1'b1; ie[5] = 1'b1; ctl[5] = 8'h80;
    ip[200] = 1'b1; ie[200] = 1'b1; ctl[200] = 8'h80;
    do_reset();
    wait_valid(40, n);
    checks++; if (valid !== 1'b1 || id !== 8'd200) begin errors++; $display("FAIL tie_id: got valid=%b id=%0d expected 1/200", valid, id); end
    checks++; if (ctlo !== 8'h80) begin errors++; $display("FAIL tie_ctl: got 0x%0h expected 0x80", ctlo); end
    ctl[5] = 8'h90;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (valid !== 1'b1 || id !== 8'd200) begin errors++; $display("FAIL no_preempt: got valid=%b id=%0d expected 1/200", valid, id); end
    ready = 1'b1;
    $display("[%0t] handshake id=%0d", $time, id);
    tick();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL tie_accept_drop: got %b expected 0", valid); end
    wait_valid(40, n);
    checks++; if (valid !== 1'b1 || id !== 8'd5) begin errors++; $display("FAIL prio_id: got valid=%b id=%0d expected 1/5", valid, id); end
    checks++; if (ctlo !== 8'h90) begin errors++; $display("FAIL prio_ctl: got 0x%0h expected 0x90", ctlo); end
  endtask

  task automatic test_threshold();
    int n;
    bit seen;
    clear_inputs();
    ip[37] = 1'b1; ie[37] = 1'b1; ctl[37] = 8'h40;
    thresh = 8'h40;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL thresh_equal_blocks: got valid seen=%b expected 0", seen); end
    thresh = 8'h3F;
    wait_valid(40, n);
    checks++; if (valid !== 1'b1 || id !== 8'd37) begin errors++; $display("FAIL thresh_lowered: got valid=%b id=%0d expected 1/37", valid, id); end
  endtask

  task automatic test_retract();
    int n;
    bit seen;
    clear_inputs();
    ip[37] = 1'b1;  ie[37] = 1'b1;  ctl[37] = 8'h40;
    ip[100] = 1'b1; ie[100] = 1'b1; ctl[100] = 8'h30;
    do_reset();
    wait_valid(40, n);
    checks++; if (valid !== 1'b1 || id !== 8'd37) begin errors++; $display("FAIL retract_first: got valid=%b id=%0d expected 1/37", valid, id); end
    ip[37] = 1'b0;
    tick();
    $display("[%0t] retract pending drop, valid=%b", $time, valid);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL retract_ip: got %b expected 0", valid); end
    wait_valid(40, n);
    checks++; if (valid !== 1'b1 || id !== 8'd100) begin errors++; $display("FAIL retract_next_id: got valid=%b id=%0d expected 1/100", valid, id); end
    checks++; if (ctlo !== 8'h30) begin errors++; $display("FAIL retract_next_ctl: got 0x%0h expected 0x30", ctlo); end
    thresh = 8'h30;
    tick();
    $display("[%0t] retract threshold raise, valid=%b", $time, valid);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL retract_thresh: got %b expected 0", valid); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL retract_quiet: got valid seen=%b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int n;
    int hs;
    bit held;
    clear_inputs();
    ip[37] = 1'b1; ie[37] = 1'b1; ctl[37] = 8'h40;
    do_reset();
    wait_valid(40, n);
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid !== 1'b1) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold: got valid=%b expected 1", valid); end
    hs = 0;
    ready = 1'b1;
    if (valid && ready) hs++;
    $display("[%0t] handshake id=%0d", $time, id);
    tick();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b expected 0", valid); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid && ready) hs++;
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b expected 0 after 15 cycles", valid); end
    tick();
    checks++; if (valid !== 1'b1 || id !== 8'd37) begin errors++; $display("FAIL b2b_reoffer: got valid=%b id=%0d expected 1/37 after 16 cycles", valid, id); end
    checks++; if (hs !== 1) begin errors++; $display("FAIL b2b_handshakes: got %0d expected 1", hs); end
  endtask

  task automatic test_reset_midflight();
    int n;
    clear_inputs();
    ip[37] = 1'b1; ie[37] = 1'b1; ctl[37] = 8'h40;
    do_reset();
    wait_valid(40, n);
    ready = 1'b1;
    $display("[%0t] handshake id=%0d", $time, id);
    tick();
    ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || id !== 8'd0 || ctlo !== 8'h00) begin errors++; $display("FAIL rst_scan: got valid=%b id=%0d ctl=0x%0h expected 0/0/0x00", valid, id, ctlo); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_scan_early: got %b expected 0 after 15 cycles", valid); end
    tick();
    checks++; if (valid !== 1'b1 || id !== 8'd37) begin errors++; $display("FAIL rst_scan_fresh: got valid=%b id=%0d expected 1/37", valid, id); end
    rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || id !== 8'd0 || ctlo !== 8'h00) begin errors++; $display("FAIL rst_offer: got valid=%b id=%0d ctl=0x%0h expected 0/0/0x00", valid, id, ctlo); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_offer_early: got %b expected 0 after 15 cycles", valid); end
    tick();
    checks++; if (valid !== 1'b1 || id !== 8'd37 || ctlo !== 8'h40) begin errors++; $display("FAIL rst_offer_fresh: got valid=%b id=%0d ctl=0x%0h expected 1/37/0x40", valid, id, ctlo); end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_tie_break();
    test_threshold();
    test_retract();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
